hazard_scheduler: RTL and testbench

//  Central timing sequencer for the hazard grid. Replaces the free-running divided clocks with

---
 rtl/hazard_scheduler_if.sv | 23 ++
 rtl/hazard_scheduler.sv | 124 ++++++++++++
 tb/tb_hazard_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_if.sv
// Control/status bundle between the game FSM (master) and the hazard scheduler (slave).
interface hazard_scheduler_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             run;
  logic             pause;
  logic [3:0]       score;
  logic             warn_active;
  logic             fire_tick;
  logic             gold_tick;
  logic [CNT_W-1:0] period_o;
  logic [1:0]       state_o;

  modport master (
    output run, pause, score,
    input  warn_active, fire_tick, gold_tick, period_o, state_o
  );

  modport slave (
    input  run, pause, score,
    output warn_active, fire_tick, gold_tick, period_o, state_o
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard-grid timing sequencer: single-cycle fire/gold enables plus a warning window per step.
// Define HAZARD_SPEEDUP_EN to shorten the step period as the score rises.
module hazard_scheduler #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned MIN_PERIOD  = 12_500_000,
  parameter int unsigned STEP_DEC    = 5_000_000,
  parameter int unsigned WARN_CYCLES = 25_000_000,
  parameter int unsigned GOLD_DIV    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scheduler_if.slave   bus
);

  localparam int unsigned     GoldW    = (GOLD_DIV > 1) ? $clog2(GOLD_DIV) : 1;
  localparam logic [GoldW-1:0] GoldLast = GoldW'(GOLD_DIV - 1);
  localparam int unsigned     WideW    = CNT_W + 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCount = 2'b01,
    StWarn  = 2'b10,
    StHold  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   period_new;
  logic [GoldW-1:0]   gold_cnt_q, gold_cnt_d;
  logic               warn_q, warn_d;
  logic               fire_q, fire_d;
  logic               gold_q, gold_d;

`ifdef HAZARD_SPEEDUP_EN
  logic [WideW-1:0] dec_wide;

  // Clamp before subtracting so the period never wraps below MIN_PERIOD.
  always_comb begin
    dec_wide = WideW'(bus.score) * WideW'(STEP_DEC);
    if (dec_wide >= WideW'(BASE_PERIOD - MIN_PERIOD)) begin
      period_new = CNT_W'(MIN_PERIOD);
    end else begin
      period_new = CNT_W'(WideW'(BASE_PERIOD) - dec_wide);
    end
  end
`else
  logic unused_score;
  assign unused_score = ^bus.score;
  assign period_new   = CNT_W'(BASE_PERIOD);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    gold_cnt_d = gold_cnt_q;
    warn_d     = warn_q;
    fire_d     = 1'b0;
    gold_d     = 1'b0;

    if (!bus.run) begin
      state_d    = StIdle;
      cnt_d      = '0;
      gold_cnt_d = '0;
      warn_d     = 1'b0;
    end else if (state_q == StIdle) begin
      if (!bus.pause) begin
        state_d  = StCount;
        cnt_d    = period_new - CNT_W'(1);
        period_d = period_new;
        warn_d   = 1'b0;
      end
    end else if (bus.pause) begin
      state_d = StHold;
    end else begin
      // An unpaused HOLD cycle counts, so a pause of N cycles delays the tick by exactly N.
      if (cnt_q == '0) begin
        fire_d   = 1'b1;
        cnt_d    = period_new - CNT_W'(1);
        period_d = period_new;
        warn_d   = 1'b0;
        if (gold_cnt_q == GoldLast) begin
          gold_cnt_d = '0;
          gold_d     = 1'b1;
        end else begin
          gold_cnt_d = gold_cnt_q + GoldW'(1);
        end
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
        warn_d = (cnt_d < CNT_W'(WARN_CYCLES));
      end
      state_d = warn_d ? StWarn : StCount;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period_q   <= CNT_W'(BASE_PERIOD);
      gold_cnt_q <= '0;
      warn_q     <= 1'b0;
      fire_q     <= 1'b0;
      gold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      gold_cnt_q <= gold_cnt_d;
      warn_q     <= warn_d;
      fire_q     <= fire_d;
      gold_q     <= gold_d;
    end
  end

  assign bus.warn_active = warn_q;
  assign bus.fire_tick   = fire_q;
  assign bus.gold_tick   = gold_q;
  assign bus.period_o    = period_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with a small period configuration.
module tb_hazard_scheduler;
  localparam int unsigned CNT_W = 32;
  localparam int BASE = 16;
  localparam int MINP = 8;
  localparam int DEC  = 2;
  localparam int WARN = 4;
  localparam int GOLD = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  hazard_scheduler_if #(.CNT_W(CNT_W)) hif ();

  hazard_scheduler #(
    .CNT_W      (CNT_W),
    .BASE_PERIOD(BASE),
    .MIN_PERIOD (MINP),
    .STEP_DEC   (DEC),
    .WARN_CYCLES(WARN),
    .GOLD_DIV   (GOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_period(input int s);
    int p;
`ifdef HAZARD_SPEEDUP_EN
    p = BASE - DEC * s;
    if (p < MINP) p = MINP;
`else
    p = BASE;
`endif
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until fire_tick is seen (0 = timeout), warn cycles before it, and flags at the tick.
  task automatic wait_tick(output int n, output int warns, output logic gold,
                           output logic warn_prev, output logic warn_at);
    n = 0; warns = 0; gold = 1'b0; warn_prev = 1'b0; warn_at = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      warn_prev = hif.warn_active;
      step();
      if (hif.fire_tick) begin
        n = i; gold = hif.gold_tick; warn_at = hif.warn_active;
        break;
      end
      if (hif.warn_active) warns++;
    end
  endtask

  task automatic wait_warn(output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (hif.warn_active) begin
        n = i;
        break;
      end
    end
  endtask

  int   n, warns, exp_len, cnt_a, cnt_b, cnt_c;
  logic gold, warn_prev, warn_at;

  initial begin
    rst_n = 1'b0; hif.run = 1'b0; hif.pause = 1'b0; hif.score = 4'd0;
    step(); step();
    chk("rst_state",  hif.state_o, 0);
    chk("rst_warn",   hif.warn_active, 0);
    chk("rst_fire",   hif.fire_tick, 0);
    chk("rst_gold",   hif.gold_tick, 0);
    chk("rst_period", hif.period_o, BASE);
    rst_n = 1'b1;
    step();
    chk("idle_norun_state", hif.state_o, 0);
    hif.run = 1'b1;
    step();
    chk("start_state",  hif.state_o, 1);
    chk("start_period", hif.period_o, exp_period(0));

    // Nine steps with score changes after ticks 2 and 4.
    exp_len = exp_period(0);
    for (int i = 1; i <= 9; i++) begin
      wait_tick(n, warns, gold, warn_prev, warn_at);
      chk($sformatf("tick%0d_len", i), n, exp_len);
      chk($sformatf("tick%0d_warncnt", i), warns, WARN);
      chk($sformatf("tick%0d_warnbefore", i), warn_prev, 1);
      chk($sformatf("tick%0d_warnat", i), warn_at, 0);
      chk($sformatf("tick%0d_gold", i), gold, (i % 3 == 0));
      exp_len = exp_period(hif.score);
      chk($sformatf("tick%0d_period", i), hif.period_o, exp_len);
      if (i == 2) hif.score = 4'd3;
      if (i == 4) hif.score = 4'd6;
    end

    // Pause for 7 cycles at the start of the warning window.
    wait_warn(n);
    chk("pause_warn_entry", n, exp_len - WARN);
    hif.pause = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (hif.warn_active) cnt_a++;
      if (hif.fire_tick) cnt_b++;
      if (hif.state_o == 2'd3) cnt_c++;
    end
    chk("hold_warn", cnt_a, 7);
    chk("hold_ticks", cnt_b, 0);
    chk("hold_state", cnt_c, 7);
    hif.pause = 1'b0;
    wait_tick(n, warns, gold, warn_prev, warn_at);
    chk("resume_len", n, WARN);
    chk("resume_warncnt", warns, WARN - 1);
    chk("tick10_gold", gold, 0);

    // run=0 in the warning window.
    wait_warn(n);
    chk("abort_warn_entry", n, exp_len - WARN);
    hif.run = 1'b0;
    step();
    chk("abort_state",  hif.state_o, 0);
    chk("abort_warn",   hif.warn_active, 0);
    chk("abort_fire",   hif.fire_tick, 0);
    chk("abort_period", hif.period_o, exp_len);
    cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (hif.fire_tick) cnt_b++;
    end
    chk("idle_ticks", cnt_b, 0);
    hif.run = 1'b1; hif.pause = 1'b1;
    step(); step(); step();
    chk("idle_paused_state", hif.state_o, 0);
    hif.pause = 1'b0;
    step();
    chk("restart_state", hif.state_o, 1);
    for (int i = 1; i <= 3; i++) begin
      wait_tick(n, warns, gold, warn_prev, warn_at);
      chk($sformatf("restart%0d_len", i), n, exp_len);
      chk($sformatf("restart%0d_gold", i), gold, (i == 3));
    end

    // Asynchronous reset in the middle of a warning window.
    wait_warn(n);
    chk("pre_rst_warn", hif.warn_active, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state",  hif.state_o, 0);
    chk("async_rst_warn",   hif.warn_active, 0);
    chk("async_rst_fire",   hif.fire_tick, 0);
    chk("async_rst_gold",   hif.gold_tick, 0);
    chk("async_rst_period", hif.period_o, BASE);
    #1;
    rst_n = 1'b1;
    hif.score = 4'd7;
    step();
    chk("score7_period", hif.period_o, exp_period(7));
    wait_tick(n, warns, gold, warn_prev, warn_at);
    chk("score7_len", n, exp_period(7));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
